// File: rtl/conc_stim_sequencer.sv
// Replays a small opcode memory onto line1/line2/obs, once or looped, one opcode per clock.
// Optional pass counter output is enabled with `define CONC_PASS_COUNT_EN.
module conc_stim_sequencer #(
  parameter int OP_W  = 3,
  parameter int DEPTH = 10,
  parameter int AW    = 4,
  parameter int PC_W  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [OP_W-1:0] load_data,
  input  logic            start,
  input  logic            stop,
  input  logic            loop_en,
  output logic            line1,
  output logic            line2,
  output logic            obs,
  output logic            stim_valid,
  output logic            busy,
  output logic            done,
`ifdef CONC_PASS_COUNT_EN
  output logic [15:0]     pass_cnt,
`endif
  output logic [PC_W-1:0] step_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic            at_end;
  logic [OP_W-1:0] mem [DEPTH];

  logic            wr_en;
  logic            ptr_last;
  logic [OP_W-1:0] rd_op;

  // Widen before comparing so DEPTH == 2**AW still bounds correctly.
  assign wr_en    = load_en && (state != RUN) &&
                    ({1'b0, load_addr} < (AW+1)'(DEPTH));
  assign ptr_last = (ptr == AW'(DEPTH - 1));
  assign rd_op    = mem[ptr];

  // Memory needs a reset clear, so it is kept in flops rather than block RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      at_end     <= 1'b0;
      line1      <= 1'b0;
      line2      <= 1'b0;
      obs        <= 1'b0;
      stim_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_cnt   <= '0;
`ifdef CONC_PASS_COUNT_EN
      pass_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            ptr      <= '0;
            at_end   <= 1'b0;
            step_cnt <= '0;
`ifdef CONC_PASS_COUNT_EN
            pass_cnt <= '0;
`endif
          end
        end

        RUN: begin
          if (stop) begin
            state      <= IDLE;
            busy       <= 1'b0;
            at_end     <= 1'b0;
            line1      <= 1'b0;
            line2      <= 1'b0;
            obs        <= 1'b0;
            stim_valid <= 1'b0;
          end else if (at_end && !loop_en) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            at_end     <= 1'b0;
            line1      <= 1'b0;
            line2      <= 1'b0;
            obs        <= 1'b0;
            stim_valid <= 1'b0;
`ifdef CONC_PASS_COUNT_EN
            if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
`endif
          end else begin
            // at_end with loop_en lands here: ptr already wrapped to 0.
            line1      <= rd_op[0];
            line2      <= rd_op[1];
            obs        <= rd_op[2];
            stim_valid <= 1'b1;
            step_cnt   <= step_cnt + 1'b1;
            ptr        <= ptr_last ? '0 : ptr + 1'b1;
            at_end     <= ptr_last;
`ifdef CONC_PASS_COUNT_EN
            if (at_end && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
`endif
          end
        end

        DONE: begin
          if (stop) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            ptr      <= '0;
            at_end   <= 1'b0;
            step_cnt <= '0;
`ifdef CONC_PASS_COUNT_EN
            pass_cnt <= '0;
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conc_stim_sequencer.sv
// Directed plus randomized bench for conc_stim_sequencer against a count-based playback model.
// Honours CONC_PASS_COUNT_EN when the build defines it.
module tb_conc_stim_sequencer;

  localparam int DEPTH = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [2:0]  load_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        line1, line2, obs, stim_valid, busy, done;
  logic [31:0] step_cnt;
`ifdef CONC_PASS_COUNT_EN
  logic [15:0] pass_cnt;
`endif

  conc_stim_sequencer dut (
    .clock(clock), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stop(stop), .loop_en(loop_en),
    .line1(line1), .line2(line2), .obs(obs),
    .stim_valid(stim_valid), .busy(busy), .done(done),
`ifdef CONC_PASS_COUNT_EN
    .pass_cnt(pass_cnt),
`endif
    .step_cnt(step_cnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model: mode 0=idle 1=run 2=done; playback tracked as entries presented since start.
  logic [2:0]  m_mem [DEPTH];
  int          m_mode;
  int          m_shown;
  logic [31:0] m_step;
  int          m_pass;
  logic [2:0]  m_op;
  bit          m_valid;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 3'b000;
    m_mode = 0; m_shown = 0; m_step = 0; m_pass = 0; m_op = 0; m_valid = 0;
  endtask

  task automatic model_clock();
    bit pass_done;
    pass_done = (m_shown > 0) && (m_shown % DEPTH == 0);
    if (load_en && m_mode != 1 && load_addr < DEPTH) m_mem[load_addr] = load_data;
    if (m_mode == 1) begin
      if (stop) begin
        m_mode = 0; m_op = 0; m_valid = 0;
      end else if (pass_done && !loop_en) begin
        m_mode = 2; m_op = 0; m_valid = 0;
        if (m_pass < 16'hFFFF) m_pass++;
      end else begin
        if (pass_done && m_pass < 16'hFFFF) m_pass++;
        m_op = m_mem[m_shown % DEPTH];
        m_valid = 1;
        m_shown++;
        m_step = m_step + 32'd1;
      end
    end else if (m_mode == 2 && stop) begin
      m_mode = 0;
    end else if (start) begin
      m_mode = 1; m_shown = 0; m_step = 0; m_pass = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_outs"}, 64'({obs, line2, line1, stim_valid, busy, done}),
        64'({m_op, m_valid, m_mode == 1, m_mode == 2}));
    chk({tag, "_step"}, 64'(step_cnt), 64'(m_step));
`ifdef CONC_PASS_COUNT_EN
    chk({tag, "_pass"}, 64'(pass_cnt), 64'(m_pass));
`endif
  endtask

  // Apply inputs for one edge, advance model and DUT, compare shortly after the edge.
  task automatic cyc(input string tag, input bit s, input bit p, input bit le,
                     input bit ld, input int a, input int d);
    start = s; stop = p; loop_en = le; load_en = ld;
    load_addr = 4'(a); load_data = 3'(d);
    @(posedge clock);
    model_clock();
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [2:0] plan [DEPTH];
    plan[0] = 3'b000; plan[1] = 3'b001; plan[2] = 3'b010; plan[3] = 3'b011; plan[4] = 3'b100;
    plan[5] = 3'b101; plan[6] = 3'b110; plan[7] = 3'b111; plan[8] = 3'b001; plan[9] = 3'b010;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    chk_all("reset");
    #3 reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) cyc("load", 0, 0, 0, 1, i, int'(plan[i]));

    // One-shot playback: 10 entries then DONE.
    cyc("oneshot_start", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc("oneshot_play", 0, 0, 0, 0, 0, 0);
      chk("oneshot_entry", 64'({obs, line2, line1}), 64'(plan[i]));
    end
    cyc("oneshot_end", 0, 0, 0, 0, 0, 0);
    chk("oneshot_done", 64'({done, stim_valid}), 64'(2'b10));
    chk("oneshot_steps", 64'(step_cnt), 64'd10);

    // Looped playback with an ignored load to entry 0 while running.
    cyc("loop_start", 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 24; i++) cyc("loop_play", 0, 0, 1, (i == 3), 0, 7);
    chk("loop_busy", 64'(busy), 64'd1);

    // Stop mid-run, then restart from entry 0.
    cyc("stop", 0, 1, 1, 0, 0, 0);
    cyc("restart", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("restart_play", 0, 0, 0, 0, 0, 0);
    cyc("stop2", 0, 1, 0, 0, 0, 0);
    chk("stop_steps", 64'(step_cnt), 64'd4);
    cyc("restart2", 1, 0, 0, 0, 0, 0);
    cyc("restart2_first", 0, 0, 0, 0, 0, 0);
    chk("restart_first", 64'({obs, line2, line1, step_cnt}), 64'({plan[0], 32'd1}));

    // Out-of-range load from IDLE, then full one-shot playback.
    cyc("stop3", 0, 1, 0, 0, 0, 0);
    cyc("oor_load", 0, 0, 0, 1, 12, 5);
    cyc("oor_start", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) cyc("oor_play", 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit s, p;
      p = ($urandom_range(0, 99) < 5);
      s = !p && ($urandom_range(0, 99) < 12);
      cyc("rand", s, p, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 25),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
    end

    // Async reset in the middle of a run.
    cyc("ar_load", 0, 1, 0, 1, 2, 7);
    cyc("ar_start", 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("ar_play", 0, 0, 1, 0, 0, 0);
    start = 0; stop = 0; load_en = 0;
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk_all("async_reset");
    #2 reset = 1'b1;
    cyc("ar_restart", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc("ar_zero_play", 0, 0, 0, 0, 0, 0);
      chk("ar_zero_op", 64'({obs, line2, line1, stim_valid}), 64'(4'b0001));
    end
    cyc("ar_done", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conc_stim_sequencer.md
Name: conc_stim_sequencer

Overview:
- Synthesizable replay engine for concolic test vectors. Sits directly upstream of the design under test (e.g. b01) and drives its data inputs.
- Holds a small opcode memory loaded through a write port. On start it steps a program counter and presents one opcode per clock as line1/line2/obs.
- Supports one-shot or looped playback, stop, and a pass counter.

Parameters:
- OP_W, 3, opcode width; bit0=line1, bit1=line2, bit2=obs.
- DEPTH, 10, number of opcode entries (>=2).
- AW, 4, address width; DEPTH <= 2**AW.
- PC_W, 32, width of the exported step counter.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  write strobe for opcode memory.
- load_addr  in  AW  write address.
- load_data  in  OP_W  write data.
- start  in  1  begin playback from entry 0.
- stop  in  1  abort playback.
- loop_en  in  1  wrap to entry 0 after last entry instead of finishing.
- line1  out  1  opcode bit0 to DUT.
- line2  out  1  opcode bit1 to DUT.
- obs  out  1  opcode bit2 to DUT observation input.
- stim_valid  out  1  high while line1/line2/obs carry a played opcode.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- step_cnt  out  PC_W  opcodes issued since last start.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; rd pointer 0; step_cnt 0; all memory entries cleared to 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop.
  - RUN -> DONE after the last entry when loop_en=0.
  - DONE -> RUN on start.
  - DONE -> IDLE on stop.
- Priority in RUN: stop beats start and beats wrap/finish.
- Load:
  - Memory is written on load_en when state != RUN.
  - load_en in RUN is ignored.
  - Addresses >= DEPTH are ignored.
- start in IDLE/DONE, edge k:
  - At edge k+1, outputs present mem[0] and stim_valid=1.
  - Each later edge presents the next entry.
  - step_cnt increments with each presented entry, wrapping mod 2**PC_W.
  - One-cycle latency from start to first opcode.
- start asserted while already in RUN with no stop: ignored.
- Last entry mem[DEPTH-1] presented at edge j:
  - loop_en=1: mem[0] presented at edge j+1; stays in RUN.
  - loop_en=0: DONE at edge j+1; line1/line2/obs/stim_valid forced 0; done=1.
  - loop_en is sampled on the edge that would wrap.
- stop in RUN: next edge IDLE; line1/line2/obs/stim_valid=0; step_cnt holds its value.
- start in IDLE/DONE clears step_cnt to 0 on that same edge, then counts from the first presented entry.
- Reset mid-RUN: immediate return to reset state; memory contents are lost.
- busy=(state==RUN); done=(state==DONE). Both are registered, with no combinational path from inputs.
- line1/line2/obs are 0 whenever stim_valid=0.

Optional Feature:
- CONC_PASS_COUNT_EN defined:
  - Adds output pass_cnt[15:0], reset 0, cleared on start.
  - Increments on each completed pass, i.e. each wrap from DEPTH-1 to 0, or the transition to DONE.
  - Saturates at 16'hFFFF.
- Not defined: no pass_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset then idle: load 0..9 with 3'b000..3'b111,3'b001,3'b010; start pulse at edge 0 -> edges 1..10 present those values on {obs,line2,line1}, stim_valid=1; edge 11 done=1, outputs 0, step_cnt=10.
- Loop: same memory, loop_en=1, start -> edge 11 presents mem[0] again, busy stays 1; step_cnt=11 at edge 11; with CONC_PASS_COUNT_EN, pass_cnt=1 at edge 11.
- Stop mid-run: stop at edge 4 -> edge 5 state IDLE, outputs 0, step_cnt=4; then start -> first output is mem[0], step_cnt restarts at 1.
- Load during RUN: load_en with addr 0, data 3'b111 while busy -> mem[0] unchanged on the next pass (loop_en=1).
- Out-of-range load: load_addr=12, data 3'b101 -> no entry changes; full playback is identical to before.
- Async reset asserted mid-cycle during RUN -> outputs, busy, done and step_cnt go 0 without waiting for a clock edge; subsequent start plays all-zero opcodes with stim_valid=1.
